param_microprocessor: RTL and testbench
=======================================

PARAM_MICROPROCESSOR -- requirements
Module: param_microprocessor

Interface
REQ-001 Parameter DW, default 8, accumulator and I/O data width; legal range 2..32.
REQ-002 Parameter AW, default 4, program address width; legal range 2..8; instruction width IW = 3+AW.
REQ-003 Clock  input  1  single clock for all state.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  launches program execution from HALT.
REQ-006 In  input  DW  input data word.
REQ-007 InValid  input  1  In holds a valid word.
REQ-008 InReady  output  1  core accepts In this cycle.
REQ-009 Out  output  DW  registered output word, holds last OUT value.
REQ-010 OutValid  output  1  one-cycle strobe, Out updated this cycle.
REQ-011 Halt  output  1  core is in HALT state.
REQ-012 ProgWe  input  1  program-memory write enable.
REQ-013 ProgAddr  input  AW  program-memory write address.
REQ-014 ProgData  input  IW  program-memory write data.

Function
REQ-015 Instruction: opcode = bits [IW-1:AW]; operand = bits [AW-1:0], used as a jump target.
REQ-016 Opcodes: 000 NOP, 001 IN, 010 OUT, 011 DEC, 100 JNZ, 101 JZ, 110 INC (see REQ-033), 111 HALT.
REQ-017 FSM states: HALT, FETCH, EXEC.
REQ-018 HALT to FETCH on Start=1, with PC <= 0 and A unchanged; Start is ignored in FETCH and EXEC.
REQ-019 FETCH takes one cycle: IR <= mem[PC]; PC <= PC+1 mod 2^AW (15 wraps to 0 when AW=4); next state EXEC.
REQ-020 EXEC takes one cycle and returns to FETCH, except for IN (REQ-021) and HALT (REQ-028).
REQ-021 IN: InReady=1 for the whole EXEC cycle; on InValid&InReady, A <= In and go to FETCH; otherwise stay in EXEC with A and PC unchanged.
REQ-022 InReady=0 in every state other than EXEC-with-IN.
REQ-023 OUT: Out <= A; OutValid=1 for exactly the following cycle.
REQ-024 DEC: A <= A-1 mod 2^DW (0 wraps to all-ones).
REQ-025 INC (when enabled): A <= A+1 mod 2^DW (all-ones wraps to 0).
REQ-026 JNZ: if A!=0 then PC <= operand, overriding the FETCH increment; otherwise PC is unchanged.
REQ-027 JZ: if A==0 then PC <= operand; otherwise PC is unchanged.
REQ-028 HALT opcode: next state HALT; Halt=1 from the following cycle.
REQ-029 Program memory: 2^AW words x IW, synchronous write, combinational read.
REQ-030 ProgWe takes effect only in the HALT state; it is ignored in FETCH and EXEC.
REQ-031 Simultaneous Start and ProgWe in HALT: the write completes and the FETCH on the next cycle reads the new word.

Reset
REQ-032 Reset=0 forces state=HALT, PC=0, A=0, IR=0, Out=0, OutValid=0, InReady=0 and Halt=1, immediately and independent of Clock; program memory is not cleared; reset mid-IN abandons the transfer.

Configuration
REQ-033 Macro PMP_INC_EN: when defined, opcode 110 executes INC; when undefined, opcode 110 executes as NOP and no incrementer is built.

Structure
REQ-034 Package pmp_pkg holds the opcode constants, the FSM state enum and the IW derivation function.
REQ-035 Program memory is sub-module pmp_prog_mem, parametrised by AW and IW; FSM and datapath stay in the top module.

Verification (DW=8, AW=4)
REQ-036 Load IN, OUT, DEC, JNZ 1, HALT; Start; In=3 with InValid=1 -> Out strobes 3, 2, 1, then Halt=1, and A=0 at halt.
REQ-037 IN with InValid held low for 5 cycles -> InReady=1 throughout, A/PC/state frozen; InValid=1 -> A loads on that edge.
REQ-038 A=0, DEC, JNZ 7 -> A=255 and PC=7.
REQ-039 Memory of 16 NOPs with HALT at address 2; Start at PC=0 -> PC advances 0,1,2 and halts; separately, a NOP at address 15 wraps PC to 0.
REQ-040 ProgWe pulse during EXEC leaves memory unchanged; Reset=0 during IN wait -> Halt=1 and InReady=0 with no clock edge.
REQ-041 A=255, opcode 110 -> A=0 with PMP_INC_EN defined; A=255 unchanged without it.

Source files
------------

// File: rtl/pmp_pkg.sv
// Shared definitions for the parameterised accumulator microprocessor:
// opcode values, FSM state encoding and the instruction-width helper.
package pmp_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_e;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_IN   = 3'b001;
  localparam logic [2:0] OP_OUT  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_JNZ  = 3'b100;
  localparam logic [2:0] OP_JZ   = 3'b101;
  localparam logic [2:0] OP_INC  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Instruction word is a 3-bit opcode followed by an AW-bit jump target.
  function automatic int pmp_iw(input int aw);
    return aw + 3;
  endfunction

endpackage

// File: rtl/pmp_prog_mem.sv
// Program store: 2^AW words of IW bits, synchronous write, combinational read.
// Contents are deliberately not reset so a loaded program survives rst_ni.
module pmp_prog_mem #(
  parameter int AW = 4,
  parameter int IW = 7
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [IW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [IW-1:0] rdata_o
);

  logic [IW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_microprocessor.sv
// Accumulator microprocessor with HALT/FETCH/EXEC control and handshaked I/O.
// Define PMP_INC_EN to make opcode 110 an increment; otherwise it acts as NOP.
module param_microprocessor
  import pmp_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4,
  localparam int IW = pmp_iw(AW)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [DW-1:0] in_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic [DW-1:0] out_o,
  output logic          out_valid_o,
  output logic          halt_o,
  input  logic          prog_we_i,
  input  logic [AW-1:0] prog_addr_i,
  input  logic [IW-1:0] prog_data_i
);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] a_q, a_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [DW-1:0] out_q, out_d;
  logic          out_valid_q, out_valid_d;

  logic [IW-1:0] mem_rdata;
  logic [2:0]    opcode;
  logic [AW-1:0] operand;
  logic          mem_we;

  assign opcode  = ir_q[IW-1:AW];
  assign operand = ir_q[AW-1:0];

  // Writes are only honoured while halted so a running program cannot be altered.
  assign mem_we = prog_we_i && (state_q == ST_HALT);

  pmp_prog_mem #(
    .AW(AW),
    .IW(IW)
  ) u_prog_mem (
    .clk_i  (clk_i),
    .we_i   (mem_we),
    .waddr_i(prog_addr_i),
    .wdata_i(prog_data_i),
    .raddr_i(pc_q),
    .rdata_o(mem_rdata)
  );

  assign in_ready_o  = (state_q == ST_EXEC) && (opcode == OP_IN);
  assign halt_o      = (state_q == ST_HALT);
  assign out_o       = out_q;
  assign out_valid_o = out_valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_HALT;
      pc_q        <= '0;
      a_q         <= '0;
      ir_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      a_q         <= a_d;
      ir_q        <= ir_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    a_d         = a_q;
    ir_d        = ir_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_HALT: begin
        if (start_i) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + AW'(1);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        // Jumps overwrite the PC that FETCH already advanced.
        case (opcode)
          OP_IN: begin
            if (in_valid_i) begin
              a_d = in_i;
            end else begin
              state_d = ST_EXEC;
            end
          end
          OP_OUT: begin
            out_d       = a_q;
            out_valid_d = 1'b1;
          end
          OP_DEC: a_d = a_q - DW'(1);
          OP_JNZ: begin
            if (a_q != '0) pc_d = operand;
          end
          OP_JZ: begin
            if (a_q == '0) pc_d = operand;
          end
`ifdef PMP_INC_EN
          OP_INC: a_d = a_q + DW'(1);
`else
`endif
          OP_HALT: state_d = ST_HALT;
          default: ;
        endcase
      end
      default: state_d = ST_HALT;
    endcase
  end

endmodule

// File: tb/tb_param_microprocessor.sv
// Self-checking bench for param_microprocessor (DW=8, AW=4): directed programs
// plus random programs compared against an instruction-level interpreter.
module tb_param_microprocessor;

  localparam int DEPTH = 16;
  localparam logic [2:0] opNop  = 3'd0;
  localparam logic [2:0] opIn   = 3'd1;
  localparam logic [2:0] opOut  = 3'd2;
  localparam logic [2:0] opDec  = 3'd3;
  localparam logic [2:0] opJnz  = 3'd4;
  localparam logic [2:0] opJz   = 3'd5;
  localparam logic [2:0] opInc  = 3'd6;
  localparam logic [2:0] opHalt = 3'd7;

  logic       clk = 1'b0;
  logic       rstN;
  logic       start;
  logic [7:0] inWord;
  logic       inValid;
  logic       inReady;
  logic [7:0] outWord;
  logic       outValid;
  logic       halt;
  logic       progWe;
  logic [3:0] progAddr;
  logic [6:0] progData;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] prog [DEPTH];
  logic [7:0] feed[$];
  logic [7:0] expOut[$];
  logic [7:0] obsOut[$];
  int         feedIdx;
  logic [7:0] curA;
  logic [7:0] modelA;
  int         modelPc;
  bit         modelHalted;
  int         cyc;

  param_microprocessor dut (
    .clk_i      (clk),
    .rst_ni     (rstN),
    .start_i    (start),
    .in_i       (inWord),
    .in_valid_i (inValid),
    .in_ready_o (inReady),
    .out_o      (outWord),
    .out_valid_o(outValid),
    .halt_o     (halt),
    .prog_we_i  (progWe),
    .prog_addr_i(progAddr),
    .prog_data_i(progData)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (outValid === 1'b1) obsOut.push_back(outWord);
  end

  function automatic logic [6:0] enc(input logic [2:0] op, input logic [3:0] opd);
    return {op, opd};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fillProg(input logic [6:0] word);
    for (int i = 0; i < DEPTH; i++) prog[i] = word;
  endtask

  // Executes the program one instruction at a time from PC 0 with A = curA.
  task automatic runModel();
    logic [7:0] a;
    logic [6:0] word;
    int pc;
    int idx;
    a = curA;
    pc = 0;
    idx = 0;
    modelHalted = 0;
    expOut.delete();
    for (int step = 0; step < 64 && !modelHalted; step++) begin
      word = prog[pc];
      pc = (pc + 1) % DEPTH;
      case (word[6:4])
        opIn: begin
          a = (idx < feed.size()) ? feed[idx] : 8'h00;
          idx++;
        end
        opOut: expOut.push_back(a);
        opDec: a = a - 8'd1;
        opJnz: if (a != 0) pc = int'(word[3:0]);
        opJz:  if (a == 0) pc = int'(word[3:0]);
`ifdef PMP_INC_EN
        opInc: a = a + 8'd1;
`endif
        opHalt: modelHalted = 1;
        default: ;
      endcase
    end
    modelA = a;
    modelPc = pc;
  endtask

  task automatic loadProgram();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      progWe = 1'b1;
      progAddr = 4'(i);
      progData = prog[i];
    end
    @(negedge clk);
    progWe = 1'b0;
  endtask

  task automatic startRun();
    obsOut.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    while (inReady !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "/inReady"}, 32'(inReady), 32'd1);
  endtask

  task automatic waitHalt(input string tag);
    int n = 0;
    while (halt !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "/halted"}, 32'(halt), 32'd1);
  endtask

  // Starts the loaded program, serving inputs from feed with random gaps, and
  // compares outputs, final A and final PC against the interpreter.
  task automatic applyStimulus(input string tag, input int budget, input bit withWrite,
                               input logic [3:0] wAddr, input logic [6:0] wData,
                               output int cycles);
    if (withWrite) prog[wAddr] = wData;
    runModel();
    obsOut.delete();
    feedIdx = 0;
    @(negedge clk);
    start = 1'b1;
    if (withWrite) begin
      progWe = 1'b1;
      progAddr = wAddr;
      progData = wData;
    end
    @(negedge clk);
    start = 1'b0;
    progWe = 1'b0;
    cycles = 1;
    while (halt !== 1'b1 && cycles < budget) begin
      inValid = 1'b0;
      if (inReady === 1'b1 && $urandom_range(0, 2) != 0 && feedIdx < feed.size()) begin
        inValid = 1'b1;
        inWord = feed[feedIdx];
        feedIdx++;
      end
      @(negedge clk);
      cycles++;
    end
    inValid = 1'b0;
    checkOutput({tag, "/halted"}, 32'(halt), 32'd1);
    checkOutput({tag, "/outCount"}, obsOut.size(), expOut.size());
    for (int i = 0; i < expOut.size(); i++) begin
      checkOutput($sformatf("%s/out%0d", tag, i),
                  (i < obsOut.size()) ? 32'(obsOut[i]) : 32'hFFFF_FFFF, 32'(expOut[i]));
    end
    checkOutput({tag, "/A"}, 32'(dut.a_q), 32'(modelA));
    checkOutput({tag, "/PC"}, 32'(dut.pc_q), modelPc);
    curA = modelA;
  endtask

  initial begin
    rstN = 1'b0;
    start = 1'b0;
    inValid = 1'b0;
    inWord = 8'h00;
    progWe = 1'b0;
    progAddr = 4'h0;
    progData = 7'h00;
    curA = 8'h00;
    #12;
    checkOutput("reset/halt", 32'(halt), 32'd1);
    checkOutput("reset/outValid", 32'(outValid), 32'd0);
    checkOutput("reset/inReady", 32'(inReady), 32'd0);
    checkOutput("reset/out", 32'(outWord), 32'd0);
    checkOutput("reset/A", 32'(dut.a_q), 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    // Countdown loop: outputs 3, 2, 1 then halts with A = 0.
    fillProg(enc(opHalt, 4'd0));
    prog[0] = enc(opIn, 4'd0);
    prog[1] = enc(opOut, 4'd0);
    prog[2] = enc(opDec, 4'd0);
    prog[3] = enc(opJnz, 4'd1);
    feed = '{8'd3};
    loadProgram();
    applyStimulus("loop321", 200, 1'b0, 4'd0, 7'd0, cyc);
    checkOutput("loop321/A0", 32'(dut.a_q), 32'd0);

    // IN stall: nothing moves while InValid is low.
    fillProg(enc(opHalt, 4'd0));
    prog[0] = enc(opIn, 4'd0);
    prog[1] = enc(opOut, 4'd0);
    loadProgram();
    startRun();
    waitReady("stall");
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall/inReady", 32'(inReady), 32'd1);
      checkOutput("stall/A", 32'(dut.a_q), 32'(curA));
      checkOutput("stall/PC", 32'(dut.pc_q), 32'd1);
      @(negedge clk);
    end
    inWord = 8'h5A;
    inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("stall/Aload", 32'(dut.a_q), 32'h5A);
    checkOutput("stall/readyDrop", 32'(inReady), 32'd0);
    waitHalt("stall");
    checkOutput("stall/outCount", obsOut.size(), 32'd1);
    checkOutput("stall/out", (obsOut.size() > 0) ? 32'(obsOut[0]) : 32'hFFFF_FFFF, 32'h5A);
    curA = 8'h5A;

    // DEC from zero wraps to 255 and JNZ 7 is taken.
    fillProg(enc(opHalt, 4'd0));
    prog[0] = enc(opIn, 4'd0);
    prog[1] = enc(opDec, 4'd0);
    prog[2] = enc(opJnz, 4'd7);
    prog[7] = enc(opOut, 4'd0);
    feed = '{8'd0};
    loadProgram();
    applyStimulus("jnz7", 200, 1'b0, 4'd0, 7'd0, cyc);
    checkOutput("jnz7/A", 32'(dut.a_q), 32'hFF);

    // NOP run into HALT at address 2: fetch/exec pairs for 0, 1, 2.
    fillProg(enc(opNop, 4'd0));
    prog[2] = enc(opHalt, 4'd0);
    feed.delete();
    loadProgram();
    applyStimulus("nop3", 100, 1'b0, 4'd0, 7'd0, cyc);
    checkOutput("nop3/cycles", cyc, 32'd7);

    // PC wraps from 15 back to 0, where JZ 5 now reaches HALT.
    fillProg(enc(opHalt, 4'd0));
    prog[0] = enc(opJz, 4'd5);
    prog[1] = enc(opIn, 4'd0);
    prog[2] = enc(opJz, 4'd15);
    prog[15] = enc(opNop, 4'd0);
    feed = '{8'd0};
    loadProgram();
    applyStimulus("wrap", 200, 1'b0, 4'd0, 7'd0, cyc);
    checkOutput("wrap/PC", 32'(dut.pc_q), 32'd6);

    // Start together with a write to address 0: the new word is fetched.
    fillProg(enc(opHalt, 4'd0));
    prog[0] = enc(opOut, 4'd0);
    loadProgram();
    applyStimulus("startWrite", 100, 1'b1, 4'd0, enc(opHalt, 4'd0), cyc);
    checkOutput("startWrite/cycles", cyc, 32'd3);

    // A write attempted while executing must be ignored.
    fillProg(enc(opHalt, 4'd0));
    prog[0] = enc(opIn, 4'd0);
    prog[1] = enc(opOut, 4'd0);
    loadProgram();
    startRun();
    waitReady("weExec");
    progWe = 1'b1;
    progAddr = 4'd1;
    progData = enc(opHalt, 4'd0);
    @(negedge clk);
    progWe = 1'b0;
    inWord = 8'h33;
    inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    waitHalt("weExec");
    checkOutput("weExec/outCount", obsOut.size(), 32'd1);
    checkOutput("weExec/out", (obsOut.size() > 0) ? 32'(obsOut[0]) : 32'hFFFF_FFFF, 32'h33);

    // Asynchronous reset while waiting on IN.
    startRun();
    waitReady("rstIn");
    #2 rstN = 1'b0;
    #1;
    checkOutput("rstIn/halt", 32'(halt), 32'd1);
    checkOutput("rstIn/inReady", 32'(inReady), 32'd0);
    checkOutput("rstIn/outValid", 32'(outValid), 32'd0);
    checkOutput("rstIn/A", 32'(dut.a_q), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    curA = 8'h00;

    // Opcode 110 on A = 255.
    fillProg(enc(opHalt, 4'd0));
    prog[0] = enc(opIn, 4'd0);
    prog[1] = enc(opInc, 4'd0);
    prog[2] = enc(opOut, 4'd0);
    feed = '{8'hFF};
    loadProgram();
    applyStimulus("op110", 200, 1'b0, 4'd0, 7'd0, cyc);
`ifdef PMP_INC_EN
    checkOutput("op110/A", 32'(dut.a_q), 32'h00);
`else
    checkOutput("op110/A", 32'(dut.a_q), 32'hFF);
`endif

    // Random programs that the interpreter shows will halt.
    for (int t = 0; t < 20; t++) begin
      feed.delete();
      for (int i = 0; i < 64; i++) feed.push_back(8'($urandom_range(0, 255)));
      for (int tries = 0; tries < 100; tries++) begin
        for (int i = 0; i < DEPTH; i++) prog[i] = enc(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
        runModel();
        if (modelHalted) break;
      end
      if (!modelHalted) prog[0] = enc(opHalt, 4'd0);
      loadProgram();
      applyStimulus($sformatf("rand%0d", t), 800, 1'b0, 4'd0, 7'd0, cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
